crc32_arbiter: RTL and testbench

//  Shares one combinational CRC32_GEN instance (512-bit data, 32-bit checksum) among NUM_REQ requesters.

---
 rtl/crc32_arbiter.sv | 179 +++++++++++++++++
 tb/tb_crc32_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/crc32_arbiter.sv
// Round-robin share of one combinational CRC-32 engine among NUM_REQ requesters; CRC32_ARB_CHECK_EN adds an expected-CRC compare.
// Latency: 2 cycles from accept to rsp_valid_o; one request in flight, so at most 1 request per 3 cycles.
// Backpressure: rsp held stable until rsp_ready_i; req_ready_o stays 0 outside IDLE.

module crc32_gen #(
    parameter int                   DATA_WIDTH = 512,
    parameter int                   CRC_WIDTH  = 32,
    parameter logic [CRC_WIDTH-1:0] POLY       = 'hAF
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [CRC_WIDTH-1:0]  crc_o
);
    logic [CRC_WIDTH-1:0] crc_v;
    logic                 fb;

    // Bit-serial MSB-first LFSR, unrolled; init 0 and no final xor.
    always_comb begin
        crc_v = '0;
        fb    = 1'b0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            fb    = crc_v[CRC_WIDTH-1] ^ data_i[i];
            crc_v = {crc_v[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

    assign crc_o = crc_v;
endmodule

module crc32_arbiter #(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 512,
    parameter int  CRC_WIDTH  = 32,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [ID_W-1:0]               rsp_id_o,
    output logic [CRC_WIDTH-1:0]          rsp_crc_o
`ifdef CRC32_ARB_CHECK_EN
    ,
    input  logic [NUM_REQ*CRC_WIDTH-1:0]  req_crc_i,
    output logic                          rsp_err_o
`endif
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]        rsp_id_q, rsp_id_d;
    logic [CRC_WIDTH-1:0]   rsp_crc_q, rsp_crc_d;
`ifdef CRC32_ARB_CHECK_EN
    logic [CRC_WIDTH-1:0]   exp_q, exp_d;
    logic                   err_q, err_d;
`endif

    logic [NUM_REQ-1:0]     grant;
    logic [ID_W-1:0]        grant_id;
    logic                   grant_vld;
    logic [ID_W-1:0]        idx_v;
    logic [CRC_WIDTH-1:0]   crc;

    crc32_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .CRC_WIDTH  (CRC_WIDTH),
        .POLY       (CRC_WIDTH'('hAF))
    ) u_crc (
        .data_i (data_q),
        .crc_o  (crc)
    );

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_vld = 1'b0;
        idx_v     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_v = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!grant_vld && req_valid_i[idx_v]) begin
                grant_vld = 1'b1;
                grant_id  = idx_v;
            end
        end
        if (grant_vld) grant[grant_id] = 1'b1;
    end

    // Gated by rst_n so the grant is silent while reset is held.
    assign req_ready_o = (state_q == IDLE && rst_n) ? grant : '0;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        data_d      = data_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_crc_d   = rsp_crc_q;
`ifdef CRC32_ARB_CHECK_EN
        exp_d       = exp_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (ID_W'(k) == grant_id) begin
                            data_d = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
`ifdef CRC32_ARB_CHECK_EN
                            exp_d  = req_crc_i[k*CRC_WIDTH +: CRC_WIDTH];
`endif
                        end
                    end
                    id_d     = grant_id;
                    rr_ptr_d = ID_W'((int'(grant_id) + 1) % NUM_REQ);
                    state_d  = CALC;
                end
            end
            CALC: begin
                rsp_crc_d   = crc;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
`ifdef CRC32_ARB_CHECK_EN
                err_d       = (crc != exp_q);
`endif
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            data_q      <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_crc_q   <= '0;
`ifdef CRC32_ARB_CHECK_EN
            exp_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            data_q      <= data_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_crc_q   <= rsp_crc_d;
`ifdef CRC32_ARB_CHECK_EN
            exp_q       <= exp_d;
            err_q       <= err_d;
`endif
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_crc_o   = rsp_crc_q;
`ifdef CRC32_ARB_CHECK_EN
    assign rsp_err_o   = err_q;
`endif
endmodule

// File: tb/tb_crc32_arbiter.sv
// Directed bench for crc32_arbiter: vector table for grant order/CRC values plus reset and backpressure sequences.
module tb_crc32_arbiter;
    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      req_valid_i = '0;
    logic [2047:0]   req_data_i = '0;
    logic [3:0]      req_ready_o;
    logic            rsp_valid_o;
    logic            rsp_ready_i = 1'b0;
    logic [1:0]      rsp_id_o;
    logic [31:0]     rsp_crc_o;
`ifdef CRC32_ARB_CHECK_EN
    logic [127:0]    req_crc_i = '0;
    logic            rsp_err_o;
`endif

    crc32_arbiter #(.NUM_REQ(4), .DATA_WIDTH(512), .CRC_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_id_o    (rsp_id_o),
        .rsp_crc_o   (rsp_crc_o)
`ifdef CRC32_ARB_CHECK_EN
        ,
        .req_crc_i   (req_crc_i),
        .rsp_err_o   (rsp_err_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]         vld;
        logic [3:0][511:0]  d;
        logic [3:0]         exp_gnt;
        logic [1:0]         exp_id;
        logic [31:0]        exp_crc;
        int                 exp_gap;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_grant(output int gcyc);
        int n;
        n = 0;
        while (req_ready_o == 4'b0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (req_ready_o == 4'b0) begin
            tests++;
            fails++;
            $display("FAIL grant_timeout: no req_ready_o within %0d cycles", n);
        end
        gcyc = cyc;
    endtask

    task automatic wait_rsp(output int rcyc);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!rsp_valid_o && n < 20);
        if (!rsp_valid_o) begin
            tests++;
            fails++;
            $display("FAIL rsp_timeout: no rsp_valid_o within %0d cycles", n);
        end
        rcyc = cyc;
    endtask

    initial begin
        logic [3:0][511:0] d;
        logic [3:0]        gnt;
        int                g, r, last;

        // Reset with random inputs: every output must read zero.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid_i = 4'($urandom);
            rsp_ready_i = 1'($urandom);
            for (int k = 0; k < 64; k++) req_data_i[k*32 +: 32] = $urandom;
            #1;
            chk("rst_ready", 64'(req_ready_o), 64'h0);
            chk("rst_valid", 64'(rsp_valid_o), 64'h0);
            chk("rst_id",    64'(rsp_id_o),    64'h0);
            chk("rst_crc",   64'(rsp_crc_o),   64'h0);
        end
        @(negedge clk);
        req_valid_i = '0;
        rsp_ready_i = 1'b1;
        rst_n       = 1'b1;
        @(negedge clk); #1;
        chk("idle_ready", 64'(req_ready_o), 64'h0);

        d = '0; d[1] = 512'h2; d[2] = 512'h1;
        vecs[0] = '{4'b1111, d, 4'b0001, 2'd0, 32'h0000_0000, 0};
        vecs[1] = '{4'b1110, d, 4'b0010, 2'd1, 32'h0000_015E, 3};
        vecs[2] = '{4'b1100, d, 4'b0100, 2'd2, 32'h0000_00AF, 3};
        vecs[3] = '{4'b1000, d, 4'b1000, 2'd3, 32'h0000_0000, 3};
        d = '0; d[0] = 512'h1;
        vecs[4] = '{4'b0001, d, 4'b0001, 2'd0, 32'h0000_00AF, 0};
        d = '0; d[1] = 512'h3;
        vecs[5] = '{4'b0010, d, 4'b0010, 2'd1, 32'h0000_01F1, 0};
        d = '0; d[0] = 512'h80; d[3] = 512'h8000_0000;
        vecs[6] = '{4'b1001, d, 4'b1000, 2'd3, 32'h8000_227D, 0};
        vecs[7] = '{4'b0001, d, 4'b0001, 2'd0, 32'h0000_5780, 3};
        d = '0; d[0] = 512'h4; d[2] = 512'h100;
        vecs[8] = '{4'b0101, d, 4'b0100, 2'd2, 32'h0000_AF00, 0};
        vecs[9] = '{4'b0001, d, 4'b0001, 2'd0, 32'h0000_02BC, 3};

        last = 0;
        foreach (vecs[i]) begin
            @(negedge clk);
            req_valid_i = vecs[i].vld;
            req_data_i  = vecs[i].d;
            #1;
            wait_grant(g);
            chk($sformatf("v%0d_grant", i), 64'(req_ready_o), 64'(vecs[i].exp_gnt));
            if (vecs[i].exp_gap != 0) chk($sformatf("v%0d_gap", i), 64'(g - last), 64'(vecs[i].exp_gap));
            last = g;
            gnt  = req_ready_o;
            @(posedge clk); #1;
            req_valid_i = req_valid_i & ~gnt;
            wait_rsp(r);
            chk($sformatf("v%0d_latency", i), 64'(r - g), 64'd2);
            chk($sformatf("v%0d_id", i), 64'(rsp_id_o), 64'(vecs[i].exp_id));
            chk($sformatf("v%0d_crc", i), 64'(rsp_crc_o), 64'(vecs[i].exp_crc));
        end

        // Backpressure: response holds for 5 cycles, no new grant, then drops one cycle after release.
        @(negedge clk);
        rsp_ready_i = 1'b0;
        d = '0; d[0] = 512'h1; d[2] = 512'h2;
        req_data_i  = d;
        req_valid_i = 4'b0001;
        #1;
        wait_grant(g);
        chk("bp_grant", 64'(req_ready_o), 64'b0001);
        @(posedge clk); #1;
        req_valid_i = 4'b0100;
        wait_rsp(r);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("bp_hold_valid", 64'(rsp_valid_o), 64'h1);
            chk("bp_hold_crc",   64'(rsp_crc_o),   64'hAF);
            chk("bp_hold_id",    64'(rsp_id_o),    64'h0);
            chk("bp_hold_ready", 64'(req_ready_o), 64'h0);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk); #1;
        chk("bp_release_valid", 64'(rsp_valid_o), 64'h0);
        chk("bp_next_grant",    64'(req_ready_o), 64'b0100);
        @(posedge clk); #1;
        req_valid_i = '0;
        wait_rsp(r);
        chk("bp_next_id",  64'(rsp_id_o),  64'h2);
        chk("bp_next_crc", 64'(rsp_crc_o), 64'h15E);

        // Reset while a response is pending: dropped at once, pointer back to 0.
        @(negedge clk);
        rsp_ready_i = 1'b0;
        req_valid_i = 4'b0001;
        #1;
        wait_grant(g);
        chk("mr_grant", 64'(req_ready_o), 64'b0001);
        @(posedge clk); #1;
        req_valid_i = '0;
        wait_rsp(r);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 64'(rsp_valid_o), 64'h0);
        chk("mr_crc",   64'(rsp_crc_o),   64'h0);
        d = '0; d[0] = 512'h2; d[2] = 512'h1;
        req_data_i  = d;
        req_valid_i = 4'b0101;
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready_i = 1'b1;
        #1;
        chk("mr_first_grant", 64'(req_ready_o), 64'b0001);
        @(posedge clk); #1;
        req_valid_i = 4'b0100;
        wait_rsp(r);
        chk("mr_rsp0_id",  64'(rsp_id_o),  64'h0);
        chk("mr_rsp0_crc", 64'(rsp_crc_o), 64'h15E);
        @(negedge clk); #1;
        wait_grant(g);
        chk("mr_second_grant", 64'(req_ready_o), 64'b0100);
        @(posedge clk); #1;
        req_valid_i = '0;
        wait_rsp(r);
        chk("mr_rsp2_id",  64'(rsp_id_o),  64'h2);
        chk("mr_rsp2_crc", 64'(rsp_crc_o), 64'hAF);

`ifdef CRC32_ARB_CHECK_EN
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            d = '0; d[0] = 512'h1;
            req_data_i  = d;
            req_crc_i   = '0;
            req_crc_i[31:0] = (i == 0) ? 32'hAF : 32'hAE;
            req_valid_i = 4'b0001;
            #1;
            wait_grant(g);
            @(posedge clk); #1;
            req_valid_i = '0;
            wait_rsp(r);
            chk($sformatf("chk%0d_err", i), 64'(rsp_err_o), 64'(i));
        end
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
